// File: rtl/vx_mmu_pkg.sv
// Shared types and constants for the Vortex MMU translation stage and its
// AHB-lite page-table programming port.
package vx_mmu_pkg;

    // Widest PPN a PTE word can hold; the active width is a module parameter.
    localparam int PTE_PPN_W = 16;

    typedef struct packed {
        logic                    valid;
        logic                    writable;
        logic [29-PTE_PPN_W:0]   rsvd;
        logic [PTE_PPN_W-1:0]    ppn;
    } pte_t;

    localparam int FAULT_PEND = 0;
    localparam int FAULT_WP   = 1;
    localparam int FAULT_OOR  = 2;
    localparam int FAULT_INV  = 3;

    localparam logic [31:0] CTRL_STATUS_OFS = 32'h0;
    localparam logic [31:0] CTRL_VADDR_OFS  = 32'h4;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_BUSY    = 2'b01;
    localparam logic [1:0] HTRANS_NON_SEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ     = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE,
        ERR_1,
        ERR_2
    } ahb_err_e;

    typedef enum logic [1:0] {
        SEL_PTE,
        SEL_STATUS,
        SEL_VADDR
    } reg_sel_e;

endpackage

// File: rtl/ahb_if.sv
// AHB-lite signal bundle; ahb_s is the slave view used by the MMU register block.
interface ahb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport ahb_s (
        input  HSEL, HADDR, HWRITE, HTRANS, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

    modport ahb_m (
        output HSEL, HADDR, HWRITE, HTRANS, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/vx_mmu_ahb_regs.sv
// AHB-lite slave holding the page table and sticky fault registers; unmapped
// accesses get a two-cycle ERROR response.
module vx_mmu_ahb_regs
    import vx_mmu_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          NUM_VPAGES = 8,
    parameter int          PPN_W      = 3,
    parameter logic [31:0] CTRL_BASE  = 32'h400
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    ahb_if.ahb_s                             ahb_s,
    output logic [NUM_VPAGES-1:0]            pte_valid_o,
    output logic [NUM_VPAGES-1:0]            pte_wr_o,
    output logic [NUM_VPAGES-1:0][PPN_W-1:0] pte_ppn_o,
    input  logic                             fault_i,
    input  logic [3:1]                       fault_cause_i,
    input  logic [ADDR_W-1:0]                fault_vaddr_i,
    output logic                             fault_irq_o
);
    localparam int IDX_W = (NUM_VPAGES > 1) ? $clog2(NUM_VPAGES) : 1;

    ahb_err_e                        state_q, state_d;
    logic                            hready, hresp;
    logic                            xfer, aligned, hit_pte, hit_status, hit_vaddr, mapped;
    reg_sel_e                        sel_a;
    logic                            dphase_q, dwrite_q;
    reg_sel_e                        dsel_q;
    logic [IDX_W-1:0]                didx_q;
    logic [NUM_VPAGES-1:0]           pte_valid_q, pte_wr_q;
    logic [NUM_VPAGES-1:0][PPN_W-1:0] pte_ppn_q;
    logic [3:0]                      status_q, status_d;
    logic [ADDR_W-1:0]               vaddr_q, vaddr_d;
    logic                            wr_pte, status_clr;
    pte_t                            pte_rd;
    logic [31:0]                     rdata;
    logic                            unused_wdata;

    assign hready          = (state_q != ERR_1);
    assign hresp           = (state_q == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    assign ahb_s.HREADYOUT = hready;
    assign ahb_s.HRESP     = hresp;
    assign ahb_s.HRDATA    = rdata;

    assign xfer       = ahb_s.HSEL & hready &
                        ((ahb_s.HTRANS == HTRANS_NON_SEQ) | (ahb_s.HTRANS == HTRANS_SEQ));
    assign aligned    = (ahb_s.HADDR[1:0] == 2'b00);
    assign hit_pte    = aligned & (ahb_s.HADDR[31:2] < 30'(NUM_VPAGES));
    assign hit_status = (ahb_s.HADDR == CTRL_BASE + CTRL_STATUS_OFS);
    assign hit_vaddr  = (ahb_s.HADDR == CTRL_BASE + CTRL_VADDR_OFS);
    assign mapped     = hit_pte | hit_status | hit_vaddr;

    always_comb begin
        sel_a = SEL_PTE;
        if (hit_status) begin
            sel_a = SEL_STATUS;
        end else if (hit_vaddr) begin
            sel_a = SEL_VADDR;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ERR_IDLE: if (xfer && !mapped) state_d = ERR_1;
            ERR_1:    state_d = ERR_2;
            ERR_2:    state_d = (xfer && !mapped) ? ERR_1 : ERR_IDLE;
            default:  state_d = ERR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ERR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address phase is captured here; the data phase acts on it one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            dsel_q   <= SEL_PTE;
            didx_q   <= '0;
        end else if (hready) begin
            dphase_q <= xfer & mapped;
            dwrite_q <= ahb_s.HWRITE;
            dsel_q   <= sel_a;
            didx_q   <= ahb_s.HADDR[IDX_W+1:2];
        end
    end

    assign wr_pte     = dphase_q & dwrite_q & (dsel_q == SEL_PTE);
    assign status_clr = dphase_q & dwrite_q & (dsel_q == SEL_STATUS) & ahb_s.HWDATA[FAULT_PEND];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pte_valid_q <= '0;
            pte_wr_q    <= '0;
            pte_ppn_q   <= '0;
        end else if (wr_pte) begin
            pte_valid_q[didx_q] <= ahb_s.HWDATA[31];
            pte_wr_q[didx_q]    <= ahb_s.HWDATA[30];
            pte_ppn_q[didx_q]   <= ahb_s.HWDATA[PPN_W-1:0];
        end
    end

    // A fault arriving with a clear is recorded as the new first fault.
    always_comb begin
        status_d = status_q;
        vaddr_d  = vaddr_q;
        if (status_clr) begin
            status_d = '0;
        end
        if (fault_i && (!status_q[FAULT_PEND] || status_clr)) begin
            status_d = {fault_cause_i, 1'b1};
            vaddr_d  = fault_vaddr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
            vaddr_q  <= '0;
        end else begin
            status_q <= status_d;
            vaddr_q  <= vaddr_d;
        end
    end

    always_comb begin
        pte_rd          = '0;
        pte_rd.valid    = pte_valid_q[didx_q];
        pte_rd.writable = pte_wr_q[didx_q];
        pte_rd.ppn      = PTE_PPN_W'(pte_ppn_q[didx_q]);
        rdata           = '0;
        if (dphase_q && !dwrite_q) begin
            case (dsel_q)
                SEL_PTE:    rdata = pte_rd;
                SEL_STATUS: rdata = 32'(status_q);
                SEL_VADDR:  rdata = 32'(vaddr_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign unused_wdata = ^ahb_s.HWDATA[29:PPN_W];

    assign pte_valid_o = pte_valid_q;
    assign pte_wr_o    = pte_wr_q;
    assign pte_ppn_o   = pte_ppn_q;
    assign fault_irq_o = status_q[FAULT_PEND];

endmodule

// File: rtl/vx_mmu_xlat.sv
// Virtual-to-physical translation stage: PTE lookup, fault detection and a
// single registered output slot with valid/ready back-pressure.
module vx_mmu_xlat
    import vx_mmu_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          PAGE_BITS  = 13,
    parameter int          NUM_VPAGES = 8,
    parameter int          PPN_W      = 3,
    parameter logic [31:0] CTRL_BASE  = 32'h400
) (
    input  logic              CLK,
    input  logic              nRST,
    ahb_if.ahb_s              ahb_s,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_write,
    output logic              fault_irq
);
    localparam int VPN_W = ADDR_W - PAGE_BITS;
    localparam int IDX_W = (NUM_VPAGES > 1) ? $clog2(NUM_VPAGES) : 1;

    logic [NUM_VPAGES-1:0]            pte_valid, pte_wr;
    logic [NUM_VPAGES-1:0][PPN_W-1:0] pte_ppn;
    logic [VPN_W-1:0]                 vpn;
    logic [PAGE_BITS-1:0]             offset;
    logic [IDX_W-1:0]                 idx;
    logic                             in_range, ent_valid, ent_wr;
    logic [PPN_W-1:0]                 ent_ppn;
    logic [3:1]                       cause;
    logic                             fault, accept;
    logic [ADDR_W-1:0]                paddr;
    logic                             rsp_valid_q, rsp_valid_d;
    logic                             rsp_write_q, rsp_write_d;
    logic [ADDR_W-1:0]                rsp_addr_q, rsp_addr_d;

    vx_mmu_ahb_regs #(
        .ADDR_W     (ADDR_W),
        .NUM_VPAGES (NUM_VPAGES),
        .PPN_W      (PPN_W),
        .CTRL_BASE  (CTRL_BASE)
    ) u_regs (
        .clk_i         (CLK),
        .rst_ni        (nRST),
        .ahb_s         (ahb_s),
        .pte_valid_o   (pte_valid),
        .pte_wr_o      (pte_wr),
        .pte_ppn_o     (pte_ppn),
        .fault_i       (accept & fault),
        .fault_cause_i (cause),
        .fault_vaddr_i (req_addr),
        .fault_irq_o   (fault_irq)
    );

    assign vpn       = req_addr[ADDR_W-1:PAGE_BITS];
    assign offset    = req_addr[PAGE_BITS-1:0];
    assign in_range  = (vpn < VPN_W'(NUM_VPAGES));
    assign idx       = vpn[IDX_W-1:0];
    assign ent_valid = pte_valid[idx];
    assign ent_wr    = pte_wr[idx];
    assign ent_ppn   = pte_ppn[idx];

    always_comb begin
        paddr                      = '0;
        paddr[PAGE_BITS-1:0]       = offset;
        paddr[PAGE_BITS +: PPN_W]  = ent_ppn;
    end

    // Only one cause is reported; range is checked before the entry is trusted.
    always_comb begin
        cause = '0;
        if (!in_range) begin
            cause[FAULT_OOR] = 1'b1;
        end else if (!ent_valid) begin
            cause[FAULT_INV] = 1'b1;
        end else if (req_write && !ent_wr) begin
            cause[FAULT_WP] = 1'b1;
        end
    end

    assign fault     = |cause;
    assign req_ready = ~rsp_valid_q | rsp_ready;
    assign accept    = req_valid & req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_write_d = rsp_write_q;
        if (accept) begin
            rsp_valid_d = ~fault;
            if (!fault) begin
                rsp_addr_d  = paddr;
                rsp_write_d = req_write;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_write = rsp_write_q;

endmodule
